dbus_responder: RTL and testbench

DBUS_RESPONDER -- requirements
Module: dbus_responder

---
 rtl/dbus_responder.sv | 166 ++++++++++++++++
 tb/tb_dbus_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_responder.sv
// dbus_responder: single-port data-bus responder backed by a DEPTH x 64-bit word store.
// Latency: data_ok arrives LATENCY cycles after request acceptance (+0..3 with DBUS_RAND_DELAY_EN).
// Backpressure: one outstanding request; dreq is ignored outside IDLE, initiator holds valid until data_ok.
//
// Ports:
//   clk    - single clock, all state on posedge
//   reset  - asynchronous, active-high; aborts any in-flight transaction, store contents kept
//   dreq   - request: valid, addr, size (ignored), strobe (0 = read), data
//   dresp  - registered response: addr_ok, data_ok (one-cycle pulse), data (0 unless data_ok)
//
// Optional feature: define DBUS_RAND_DELAY_EN to add 0..3 pseudo-random WAIT cycles per request.

package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_responder
    import dbus_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [4:0]       cnt;
    logic [4:0]       cnt_nxt;
    logic             latch;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       strobe_q;
    logic [63:0]      wdata_q;
    logic [4:0]       extra;
    logic [4:0]       wait_cycles;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_is_read;
    dbus_resp_t       resp_nxt;

    logic [63:0]      mem [DEPTH];

    // Size is never needed (strobe defines lanes) and address bits outside
    // the word index are deliberately aliased away.
    logic unused_req;
    assign unused_req = ^{dreq.size, dreq.addr};

`ifdef DBUS_RAND_DELAY_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; free-running so the extra delay
    // depends on when the request arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign extra = {3'b000, lfsr[1:0]};
`else
    assign extra = 5'd0;
`endif

    // Number of WAIT cycles between acceptance and RESP.
    assign wait_cycles = 5'(LATENCY - 1) + extra;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (dreq.valid) begin
                    latch = 1'b1;
                    if (wait_cycles == 5'd0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = wait_cycles - 5'd1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 5'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 5'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY=1 the FSM jumps IDLE->RESP on the accepting edge, before
    // the latched copy exists, so the read path must look at dreq directly.
    assign rd_idx     = latch ? dreq.addr[3 +: IDX_W] : idx_q;
    assign rd_is_read = latch ? (dreq.strobe == 8'h00) : (strobe_q == 8'h00);

    // dresp is registered: compute the value it must hold in the next state.
    always_comb begin
        resp_nxt = '0;
        if (state_nxt == RESP) begin
            resp_nxt.addr_ok = 1'b1;
            resp_nxt.data_ok = 1'b1;
            resp_nxt.data    = rd_is_read ? mem[rd_idx] : 64'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            idx_q    <= '0;
            strobe_q <= 8'h00;
            wdata_q  <= 64'd0;
            dresp    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dresp <= resp_nxt;
            if (latch) begin
                idx_q    <= dreq.addr[3 +: IDX_W];
                strobe_q <= dreq.strobe;
                wdata_q  <= dreq.data;
            end
        end
    end

    // Store has no reset. A write commits on the edge that ends RESP; an
    // asynchronous reset forces state to IDLE first, so aborted writes never land.
    always_ff @(posedge clk) begin
        if (!reset && state == RESP) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dbus_responder.sv
// tb_dbus_responder: directed + random self-checking bench for dbus_responder.
// Latency: n/a (testbench).
// Backpressure: drives one request at a time, holding valid until data_ok.
module tb_dbus_responder;
    import dbus_pkg::*;

    localparam int DEPTH   = 512;
    localparam int LATENCY = 2;
    localparam int NWORDS  = 16;   // working set kept small so reads hit written words

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    dbus_req_t  dreq;
    dbus_resp_t dresp;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] model [NWORDS];
    bit          seen  [4];

    dbus_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .dreq  (dreq),
        .dresp (dresp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] s,
                                          input logic [63:0] d);
        logic [63:0] w;
        w = old;
        for (int i = 0; i < 8; i++)
            if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        return w;
    endfunction

    // Count edges until data_ok; optionally scramble dreq fields after acceptance
    // to show the latched transaction is what completes.
    task automatic wait_ok(input bit scramble, output int lat, output logic got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (dresp.data_ok === 1'b1) begin
                got = 1'b1;
                chk("addr_ok_with_data_ok", 64'(dresp.addr_ok), 64'd1);
            end else begin
                chk("data_zero_while_waiting", dresp.data, 64'd0);
                if (scramble) begin
                    dreq.addr   = $urandom;
                    dreq.strobe = 8'($urandom);
                    dreq.data   = {$urandom, $urandom};
                end
            end
        end
        if (!got) chk("data_ok_timeout", 64'(dresp.data_ok), 64'd1);
    endtask

    task automatic chk_lat(input string tag, input int lat);
`ifdef DBUS_RAND_DELAY_EN
        chk(tag, 64'(lat >= LATENCY && lat <= LATENCY + 3), 64'd1);
        if (lat >= LATENCY && lat <= LATENCY + 3) seen[lat - LATENCY] = 1'b1;
`else
        chk(tag, 64'(lat), 64'(LATENCY));
`endif
    endtask

    // Called #1 after a posedge with the DUT idle; returns #1 after the
    // posedge that ends RESP, DUT idle again.
    task automatic txn(input logic [31:0] a, input logic [7:0] s, input logic [63:0] d,
                       output logic [63:0] rd);
        int   lat;
        logic got;
        dreq.valid  = 1'b1;
        dreq.addr   = a;
        dreq.size   = 3'($urandom);
        dreq.strobe = s;
        dreq.data   = d;
        chk("idle_no_data_ok", 64'(dresp.data_ok), 64'd0);
        wait_ok(1'b1, lat, got);
        rd = dresp.data;
        if (got) chk_lat("latency", lat);
        dreq.valid = 1'b0;
        @(posedge clk);
        #1;
        chk("data_ok_single_cycle", 64'(dresp.data_ok), 64'd0);
        chk("data_zero_after_resp", dresp.data, 64'd0);
    endtask

    initial begin
        logic [63:0] rd, v;
        logic [31:0] a;
        logic [7:0]  s;
        int          idx, lat;
        logic        got;

        dreq = '0;
        for (int i = 0; i < 4; i++) seen[i] = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk("reset_dresp", 64'(dresp), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_dresp", 64'(dresp), 64'd0);

        // Fill the working set
        for (int i = 0; i < NWORDS; i++) begin
            v = {$urandom, $urandom};
            txn(32'(i * 8), 8'hFF, v, rd);
            chk("fill_write_data_zero", rd, 64'd0);
            model[i] = v;
        end

        // Full write then read back
        txn(32'h10, 8'hFF, 64'h1122334455667788, rd);
        model[2] = 64'h1122334455667788;
        txn(32'h10, 8'h00, 64'd0, rd);
        chk("full_write_readback", rd, 64'h1122334455667788);

        // Partial lane write
        txn(32'h10, 8'h0C, 64'h00000000AABB0000, rd);
        model[2] = merge(model[2], 8'h0C, 64'h00000000AABB0000);
        txn(32'h13, 8'h00, 64'd0, rd);
        chk("lane_merge_readback", rd, 64'h11223344AABB7788);

        // Back-to-back write then read, valid held high throughout
        v = {$urandom, $urandom};
        dreq.valid  = 1'b1;
        dreq.addr   = 32'h18;
        dreq.size   = 3'd3;
        dreq.strobe = 8'hFF;
        dreq.data   = v;
        wait_ok(1'b0, lat, got);
        chk("b2b_write_data_zero", dresp.data, 64'd0);
        dreq.strobe = 8'h00;
        dreq.data   = 64'd0;
        wait_ok(1'b0, lat, got);
        model[3] = v;
        chk("b2b_read_new_data", dresp.data, v);
`ifdef DBUS_RAND_DELAY_EN
        chk("b2b_gap_range", 64'(lat >= 3 && lat <= 6), 64'd1);
`else
        chk("b2b_gap", 64'(lat), 64'd3);
`endif
        dreq.valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("b2b_no_extra_pulse", 64'(dresp.data_ok), 64'd0);
        end

        // Alias wrap: addr 0x1000 maps to word 0
        txn(32'h1000, 8'hFF, 64'hDEAD, rd);
        model[0] = 64'hDEAD;
        txn(32'h0, 8'h00, 64'd0, rd);
        chk("alias_wrap_read", rd, 64'hDEAD);

        // Reset during WAIT of a write to 0x20 (word 4)
        dreq.valid  = 1'b1;
        dreq.addr   = 32'h20;
        dreq.strobe = 8'hFF;
        dreq.data   = ~model[4];
        @(posedge clk);
        #1;
        reset      = 1'b1;
        dreq.valid = 1'b0;
        #1;
        chk("reset_in_wait_dresp", 64'(dresp), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_in_wait_no_ok", 64'(dresp.data_ok), 64'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("after_abort_no_ok", 64'(dresp.data_ok), 64'd0);
        end
        txn(32'h20, 8'h00, 64'd0, rd);
        chk("abort_wait_keeps_word", rd, model[4]);

        // Reset during RESP of a write to 0x28 (word 5)
        dreq.valid  = 1'b1;
        dreq.addr   = 32'h28;
        dreq.strobe = 8'hFF;
        dreq.data   = ~model[5];
        wait_ok(1'b0, lat, got);
        reset      = 1'b1;
        dreq.valid = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_in_resp_no_ok", 64'(dresp.data_ok), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        txn(32'h28, 8'h00, 64'd0, rd);
        chk("abort_resp_keeps_word", rd, model[5]);

        // Random traffic against the word-array model
        for (int n = 0; n < 120; n++) begin
            idx = $urandom_range(0, NWORDS - 1);
            a   = ($urandom & 32'hFFFF_F007) | 32'(idx << 3);
            s   = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
            v   = {$urandom, $urandom};
            txn(a, s, v, rd);
            if (s == 8'h00) begin
                chk("rand_read", rd, model[idx]);
            end else begin
                chk("rand_write_data_zero", rd, 64'd0);
                model[idx] = merge(model[idx], s, v);
            end
        end

`ifdef DBUS_RAND_DELAY_EN
        for (int i = 0; i < 4; i++) chk("latency_value_seen", 64'(seen[i]), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
